// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with valid/ready handshakes on both sides and a flush.
module muldiv_iter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  // acc holds the product for multiplies, and {remainder, dividend/quotient} for divides;
  // mcand holds the shifting multiplicand, or the divisor magnitude in its low half.
  logic [2*XLEN-1:0] acc, acc_nxt, mcand;
  logic [XLEN-1:0]   mplier;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic              msub, neg_q, neg_r;

  logic            accept, is_div, div_signed, a_signed, b_signed, b_zero, ovf, special;
  logic [XLEN-1:0] special_res, a_mag, b_mag, result;
  logic [XLEN:0]   rem_sh, diff;

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid && in_ready && !flush;
  assign is_div      = in_op[2];
  assign div_signed  = is_div && !in_op[0];
  assign a_signed    = !is_div && (in_op[1:0] != 2'b11);
  assign b_signed    = !is_div && !in_op[1];
  assign b_zero      = (in_b == '0);
  assign ovf         = div_signed && (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (&in_b);
  assign special     = is_div && (b_zero || ovf);
  assign special_res = b_zero ? (in_op[1] ? in_a : '1) : (in_op[1] ? '0 : in_a);
  assign a_mag       = (div_signed && in_a[XLEN-1]) ? -in_a : in_a;
  assign b_mag       = (div_signed && in_b[XLEN-1]) ? -in_b : in_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : BUSY;
      BUSY:    if (cnt == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // One iteration step. The final multiplier bit of a signed rs2 has negative weight,
  // so that partial product is subtracted.
  always_comb begin
    acc_nxt = acc;
    rem_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff    = rem_sh - {1'b0, mcand[XLEN-1:0]};
    if (op_q[2]) begin
      if (!diff[XLEN]) acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else             acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else if (mplier[0]) begin
      acc_nxt = (msub && cnt == LAST) ? acc - mcand : acc + mcand;
    end
  end

  always_comb begin
    case (op_q)
      3'b000:                 result = acc_nxt[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = acc_nxt[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
      default:                result = neg_r ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      op_q     <= '0;
      msub     <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      out_data <= '0;
      out_tag  <= '0;
    end else if (accept) begin
      op_q    <= in_op;
      out_tag <= in_tag;
      cnt     <= '0;
      msub    <= b_signed;
      neg_q   <= div_signed && (in_a[XLEN-1] ^ in_b[XLEN-1]);
      neg_r   <= div_signed && in_a[XLEN-1];
      mplier  <= in_b;
      if (is_div) begin
        acc   <= {{XLEN{1'b0}}, a_mag};
        mcand <= {{XLEN{1'b0}}, b_mag};
      end else begin
        acc   <= '0;
        mcand <= {{XLEN{a_signed & in_a[XLEN-1]}}, in_a};
      end
      if (special) out_data <= special_res;
    end else if (state == BUSY && !flush) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (!op_q[2]) begin
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      if (cnt == LAST) out_data <= result;
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: a vector table of ops with hand-computed results
// and latencies, plus sequences for backpressure, flush and mid-operation reset.
module tb_muldiv_iter;
  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b, out_data;
  logic [4:0]  in_tag, out_tag;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] expd;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  muldiv_iter #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] tag, input logic [31:0] expd,
                              input int lat);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.tag = tag; v.expd = expd; v.lat = lat;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Present one request and return just after the edge that accepts it.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (!in_ready) checkOutput("in_ready wait", {31'b0, in_ready}, 32'd1);
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency counted in cycles: the accept cycle is 0, the first out_valid cycle is returned.
  task automatic waitValid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic applyStimulus(input vec_t v, output int lat);
    issue(v.op, v.a, v.b, v.tag);
    waitValid(lat);
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic expectQuiet(input string name, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checkOutput(name, seen, 0);
  endtask

  task automatic followUp(input string name);
    int lat;
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3);
    waitValid(lat);
    checkOutput({name, " data"}, out_data, 32'hFFFF_FFEB);
    checkOutput({name, " tag"}, {27'b0, out_tag}, 32'd3);
    checkOutput({name, " latency"}, lat, 33);
    releaseResult();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;

    vecs.push_back(mk("mul 7*-3",          OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 33));
    vecs.push_back(mk("mulh min*-1",       OP_MULH,   32'h8000_0000,  32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 33));
    vecs.push_back(mk("mulhsu min*ffff",   OP_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF, 5'd4,  32'h8000_0000, 33));
    vecs.push_back(mk("mulhu 8000*ffff",   OP_MULHU,  32'h8000_0000,  32'hFFFF_FFFF, 5'd5,  32'h7FFF_FFFF, 33));
    vecs.push_back(mk("mulhu ffff*ffff",   OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33));
    vecs.push_back(mk("mul -1*-1",         OP_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'h0000_0001, 33));
    vecs.push_back(mk("div -7/2",          OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFD, 33));
    vecs.push_back(mk("rem -7%2",          OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFF, 33));
    vecs.push_back(mk("divu 100/7",        OP_DIVU,   32'd100,        32'd7,         5'd10, 32'd14,        33));
    vecs.push_back(mk("remu 100%7",        OP_REMU,   32'd100,        32'd7,         5'd11, 32'd2,         33));
    vecs.push_back(mk("div -100/7",        OP_DIV,    32'hFFFF_FF9C,  32'd7,         5'd12, 32'hFFFF_FFF2, 33));
    vecs.push_back(mk("rem -100%7",        OP_REM,    32'hFFFF_FF9C,  32'd7,         5'd13, 32'hFFFF_FFFE, 33));
    vecs.push_back(mk("div 100/-7",        OP_DIV,    32'd100,        32'hFFFF_FFF9, 5'd14, 32'hFFFF_FFF2, 33));
    vecs.push_back(mk("rem 100%-7",        OP_REM,    32'd100,        32'hFFFF_FFF9, 5'd15, 32'd2,         33));
    vecs.push_back(mk("divu ffff/1",       OP_DIVU,   32'hFFFF_FFFF,  32'd1,         5'd16, 32'hFFFF_FFFF, 33));
    vecs.push_back(mk("divu 5/0",          OP_DIVU,   32'd5,          32'd0,         5'd17, 32'hFFFF_FFFF, 1));
    vecs.push_back(mk("rem 5%0",           OP_REM,    32'd5,          32'd0,         5'd18, 32'd5,         1));
    vecs.push_back(mk("div min/-1",        OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 1));
    vecs.push_back(mk("rem min%-1",        OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd20, 32'd0,         1));
    vecs.push_back(mk("div 0/0",           OP_DIV,    32'd0,          32'd0,         5'd21, 32'hFFFF_FFFF, 1));

    #3;
    checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset out_data", out_data, 32'd0);
    checkOutput("reset out_tag", {27'b0, out_tag}, 32'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i], lat);
      checkOutput({vecs[i].name, " data"}, out_data, vecs[i].expd);
      checkOutput({vecs[i].name, " tag"}, {27'b0, out_tag}, {27'b0, vecs[i].tag});
      checkOutput({vecs[i].name, " latency"}, lat, vecs[i].lat);
      releaseResult();
      checkOutput({vecs[i].name, " idle after handshake"}, {30'b0, in_ready, out_valid}, 32'd2);
    end

    // Backpressure: result and tag must hold, and a pending request must not be taken.
    issue(OP_DIVU, 32'd100, 32'd7, 5'd9);
    waitValid(lat);
    checkOutput("backpressure latency", lat, 33);
    in_op = OP_MUL; in_a = 32'd1; in_b = 32'd1; in_tag = 5'd30; in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      checkOutput("backpressure out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("backpressure data", out_data, 32'd14);
      checkOutput("backpressure tag", {27'b0, out_tag}, 32'd9);
      checkOutput("backpressure in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    releaseResult();
    checkOutput("backpressure release", {30'b0, in_ready, out_valid}, 32'd2);

    // Flush in the tenth BUSY cycle.
    issue(OP_MUL, 32'd9, 32'd9, 5'd7);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush busy idle", {30'b0, in_ready, out_valid}, 32'd2);
    expectQuiet("flush busy no result", 40);
    followUp("after busy flush");

    // Flush while DONE wins over a same-cycle out_ready.
    issue(OP_DIVU, 32'd100, 32'd7, 5'd5);
    waitValid(lat);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    checkOutput("flush done idle", {30'b0, in_ready, out_valid}, 32'd2);
    expectQuiet("flush done no result", 5);
    followUp("after done flush");

    // Flush wins over a same-cycle request (a special case would otherwise show at once).
    in_op = OP_DIVU; in_a = 32'd5; in_b = 32'd0; in_tag = 5'd22; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checkOutput("flush idle not accepted", {30'b0, in_ready, out_valid}, 32'd2);
    expectQuiet("flush idle no result", 5);

    // Asynchronous reset in the middle of BUSY.
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd12);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    checkOutput("mid rst idle", {30'b0, in_ready, out_valid}, 32'd2);
    checkOutput("mid rst out_data", out_data, 32'd0);
    checkOutput("mid rst out_tag", {27'b0, out_tag}, 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    expectQuiet("mid rst no result", 40);
    followUp("after mid rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
